// File: rtl/nios_sampler_debug_pkg.sv
// Shared definitions for the debug-slave OCI memory controller: jdo field
// offsets, FSM state encodings and command-priority decode.
package nios_sampler_debug_pkg;

  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_RDEN_BIT  = 17;
  localparam int JDO_WDATA_LSB = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_A    = 2'd1,
    CMD_B    = 2'd2,
    CMD_NA   = 2'd3
  } cmd_e;

  // Coincident pulses resolve as write > address-load > read-next.
  function automatic cmd_e decode_cmd(input logic act_b, input logic act_a,
                                      input logic no_act_a);
    if (act_b)         return CMD_B;
    else if (act_a)    return CMD_A;
    else if (no_act_a) return CMD_NA;
    else               return CMD_NONE;
  endfunction

endpackage

// File: rtl/nios_sampler_debug_ocimem_ctrl.sv
// Executes debug-slave word read/write commands against the on-chip debug RAM,
// with a stall timeout and a sticky error flag for dropped or aborted commands.
module nios_sampler_debug_ocimem_ctrl
  import nios_sampler_debug_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam int LAT_W   = $clog2(RD_LAT + 1);

  logic [2:0]        state;
  logic [STALL_W-1:0] stall_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  cmd_e              cmd;
  logic [ADDR_W-1:0] jdo_addr;
  logic              jdo_rden;
  logic [31:0]       jdo_wdata;
  logic              unused_jdo;

  // The address and write-data fields overlap in jdo; each command uses one view.
  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_rden   = jdo[JDO_RDEN_BIT];
  assign jdo_wdata  = jdo[JDO_WDATA_LSB +: 32];
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign mem_addr = MonAReg;

  always_comb begin
    cmd = decode_cmd(take_action_ocimem_b, take_action_ocimem_a,
                     take_no_action_ocimem_a);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      stall_cnt     <= '0;
      lat_cnt       <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_wdata     <= '0;
      MonDReg       <= '0;
      MonAReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          case (cmd)
            CMD_B: begin
              MonDReg       <= jdo_wdata;
              mem_wdata     <= jdo_wdata;
              monitor_ready <= 1'b0;
              mem_write     <= 1'b1;
              stall_cnt     <= '0;
              state         <= ST_WR_REQ;
            end
            CMD_A: begin
              MonAReg       <= jdo_addr;
              monitor_error <= 1'b0;
              // Address-only load completes immediately; ready shows next cycle.
              monitor_ready <= ~jdo_rden;
              if (jdo_rden) begin
                mem_read  <= 1'b1;
                stall_cnt <= '0;
                state     <= ST_RD_REQ;
              end
            end
            CMD_NA: begin
              monitor_ready <= 1'b0;
              mem_read      <= 1'b1;
              stall_cnt     <= '0;
              state         <= ST_RD_REQ;
            end
            default: ;
          endcase
        end
        ST_RD_REQ: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            lat_cnt  <= '0;
            state    <= ST_RD_WAIT;
          end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
            mem_read      <= 1'b0;
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
        end
        ST_RD_WAIT: begin
          if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
            MonDReg <= mem_rdata;
            MonAReg <= MonAReg + ADDR_W'(1);
            state   <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        ST_WR_REQ: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            MonAReg   <= MonAReg + ADDR_W'(1);
            state     <= ST_DONE;
          end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
            mem_write     <= 1'b0;
            monitor_error <= 1'b1;
            monitor_ready <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
        end
        ST_DONE: begin
          monitor_ready <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Commands outside IDLE are dropped but flagged.
      if (state != ST_IDLE && cmd != CMD_NONE)
        monitor_error <= 1'b1;
    end
  end

endmodule

// File: doc/nios_sampler_debug_ocimem_ctrl.md
Name: nios_sampler_debug_ocimem_ctrl

Overview:
- Consumes the sysclk-domain debug commands (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a) and executes word reads and writes on the on-chip debug RAM.
- Returns MonDReg, monitor_ready and monitor_error to the debug-slave wrapper inputs.
- Sits directly downstream of the debug slave sysclk stage, on the CPU clock.

Parameters:
- ADDR_W, 8, debug RAM word-address width; legal range 1..10.
- RD_LAT, 1, cycles from read acceptance to valid mem_rdata; legal range 1..3.
- TIMEOUT, 64, maximum cycles a request may be stalled by mem_waitrequest before abort.

Ports:
- clk  in  1  CPU clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  command payload from the sysclk stage.
- take_action_ocimem_a  in  1  single-cycle pulse: address-load command.
- take_action_ocimem_b  in  1  single-cycle pulse: write command.
- take_no_action_ocimem_a  in  1  single-cycle pulse: read-next command.
- mem_addr  out  ADDR_W  debug RAM word address.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data.
- mem_waitrequest  in  1  stalls the current request while high.
- MonDReg  out  32  last read or written data word.
- MonAReg  out  ADDR_W  current access address.
- monitor_ready  out  1  high when idle after a successful access.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous): state IDLE; MonDReg=0, MonAReg=0, mem_read=0, mem_write=0, mem_wdata=0, monitor_ready=0, monitor_error=0, timeout and latency counters=0.
- Reset mid-access: request deasserts immediately; the access is abandoned with no retry.
- jdo fields:
  - ADDR = jdo[26 +: ADDR_W].
  - RDEN = jdo[17].
  - WDATA = jdo[34:3].
- Command priority if pulses coincide: B > A > NA.
- Commands accepted only in IDLE; a command arriving in any other state is dropped and sets monitor_error.
- CMD_A: MonAReg<=ADDR; monitor_error<=0; monitor_ready<=0.
  - If RDEN=1, go to RD_REQ.
  - If RDEN=0, stay IDLE and set monitor_ready=1 the next cycle.
- CMD_B: MonDReg<=WDATA; mem_wdata<=WDATA; monitor_ready<=0; go to WR_REQ.
- CMD_NA: monitor_ready<=0; go to RD_REQ at the current MonAReg.
- RD_REQ:
  - mem_read=1, mem_addr=MonAReg.
  - The request is held unchanged while mem_waitrequest=1.
  - The cycle with mem_waitrequest=0 is acceptance; go to RD_WAIT.
  - mem_read is first asserted the cycle after the command pulse.
- RD_WAIT:
  - Count RD_LAT cycles after acceptance.
  - On the last count: MonDReg<=mem_rdata; MonAReg<=MonAReg+1 (wraps mod 2^ADDR_W); go to DONE.
- WR_REQ:
  - mem_write=1 with mem_addr and mem_wdata.
  - On acceptance: MonAReg<=MonAReg+1 (wrap); go to DONE.
- DONE: monitor_ready<=1; go to IDLE (one cycle).
- Timeout:
  - The stall counter runs in RD_REQ and WR_REQ and clears on entry.
  - If it reaches TIMEOUT with waitrequest still high: deassert the request, monitor_error<=1, MonAReg unchanged, MonDReg unchanged, go to IDLE with monitor_ready<=1.
- monitor_error is cleared only by CMD_A or reset.
- mem_read and mem_write are never high together.

Decomposition:
- Shared package nios_sampler_debug_pkg:
  - jdo field offsets (JDO_ADDR_LSB=26, JDO_RDEN_BIT=17, JDO_WDATA_LSB=3).
  - State enum {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE}.
  - Command-priority encoding.
- No sub-module; the FSM and counters stay in one module.

Test Plan:
- CMD_A with ADDR=0x10, RDEN=1; mem_waitrequest=0; RAM[0x10]=0xDEADBEEF -> mem_read high exactly 1 cycle at addr 0x10; MonDReg=0xDEADBEEF RD_LAT cycles later; MonAReg=0x11; monitor_ready=1.
- CMD_B WDATA=0x12345678 at MonAReg=0x11, then CMD_NA after returning to 0x11 -> write at 0x11; readback 0x12345678; MonAReg=0x12.
- CMD_A ADDR=0xFF, RDEN=1 -> read at 0xFF; MonAReg wraps to 0x00.
- mem_waitrequest held high for 70 cycles during a read (TIMEOUT=64) -> mem_read drops at cycle 64; monitor_error=1; MonDReg unchanged; the next CMD_A clears monitor_error.
- CMD_NA pulsed while in RD_WAIT -> command dropped; monitor_error=1; in-flight read completes normally.
- reset_n asserted during WR_REQ with waitrequest high -> mem_write=0 immediately; all outputs at reset values; no address increment.
